// File: rtl/guess_tracker.sv
// guess_tracker: turns raw start/guess keys into clean one-cycle events and
// runs the IDLE/PLAY/WON/LOST round controller. It counts guesses (saturating
// at 255) and ends a losing round on the limit checker's gameOver verdict.
module guess_tracker #(
  parameter int SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start_key,
  input  logic       guess_key,
  input  logic       match,
  input  logic       gameOver,
  output logic [7:0] totalGuesses,
  output logic       play,
  output logic       won,
  output logic       lost
);

  localparam int NKEYS = 2;

  // Index 0 is the start key, index 1 is the guess key.
  logic [NKEYS-1:0] key_raw;
  logic [NKEYS-1:0] key_p;
  logic             start_p;
  logic             guess_p;

  assign key_raw = {guess_key, start_key};
  assign start_p = key_p[0];
  assign guess_p = key_p[1];

  genvar gi;
  generate
    for (gi = 0; gi < NKEYS; gi++) begin : g_key
      logic [SYNC_STAGES-1:0] sync_reg;
      logic                   hist_reg;

      // Synchronizer chain plus history flop; clearing both to 0 means a key
      // held through reset release still yields exactly one pulse.
      always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
          sync_reg <= '0;
          hist_reg <= 1'b0;
        end else begin
          sync_reg <= {sync_reg[SYNC_STAGES-2:0], key_raw[gi]};
          hist_reg <= sync_reg[SYNC_STAGES-1];
        end
      end

      // Rising-edge detect on the synchronized key: one pulse per press.
      assign key_p[gi] = sync_reg[SYNC_STAGES-1] & ~hist_reg;
    end
  endgenerate

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PLAY = 2'd1,
    WON  = 2'd2,
    LOST = 2'd3
  } state_t;

  state_t     state_reg;
  logic [7:0] count_reg;
  logic [7:0] count_inc;
  logic       play_reg;
  logic       won_reg;
  logic       lost_reg;

  // Saturating increment: a guess at 255 leaves the count at 255.
  assign count_inc = (count_reg == 8'hFF) ? count_reg : count_reg + 8'd1;

  // Round state machine; the status flags are registered alongside the state.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg <= IDLE;
      count_reg <= 8'd0;
      play_reg  <= 1'b0;
      won_reg   <= 1'b0;
      lost_reg  <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (start_p) begin
            state_reg <= PLAY;
            count_reg <= 8'd0;
            play_reg  <= 1'b1;
            won_reg   <= 1'b0;
            lost_reg  <= 1'b0;
          end
        end
        PLAY: begin
          if (start_p) begin
            // Restart wins over any coincident guess, which is dropped.
            count_reg <= 8'd0;
          end else if (guess_p) begin
            count_reg <= count_inc;
            if (match) begin
              // The winning guess is counted and beats a same-cycle gameOver.
              state_reg <= WON;
              play_reg  <= 1'b0;
              won_reg   <= 1'b1;
            end
          end else if (gameOver) begin
            state_reg <= LOST;
            play_reg  <= 1'b0;
            lost_reg  <= 1'b1;
          end
        end
        WON, LOST: begin
          if (start_p) begin
            state_reg <= PLAY;
            count_reg <= 8'd0;
            play_reg  <= 1'b1;
            won_reg   <= 1'b0;
            lost_reg  <= 1'b0;
          end
        end
        default: begin
          state_reg <= IDLE;
          count_reg <= 8'd0;
          play_reg  <= 1'b0;
          won_reg   <= 1'b0;
          lost_reg  <= 1'b0;
        end
      endcase
    end
  end

  assign totalGuesses = count_reg;
  assign play         = play_reg;
  assign won          = won_reg;
  assign lost         = lost_reg;

endmodule
